// File: rtl/rv_pipe_pkg.sv
// Shared RV32IM pipeline definitions: datapath width, PC increment,
// reset vector and the fetch sequencer state encoding.
package rv_pipe_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    PCS_BOOT = 2'd0,
    PCS_RUN  = 2'd1,
    PCS_PEND = 2'd2
  } pcs_state_e;

endpackage

// File: rtl/perf_counter.sv
// Wrapping event counter with enable and asynchronous active-high reset.
module perf_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: sequential fetch, EX redirects (with a pending
// slot when imem is busy), load-use and mul/div stalls, plus perf counters.
module pc_sequencer
  import rv_pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_addr,
  input  logic             stall_req,
  input  logic             muldiv_busy,
  input  logic             imem_ready,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             fetch_valid,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             misalign_err,
  output logic [CNT_W-1:0] redirect_count,
  output logic [CNT_W-1:0] stall_count
);

  pcs_state_e      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pending_q, pending_d;
  logic            fetch_valid_q, fetch_valid_d;
  logic            misalign_q, misalign_d;

  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] target_aligned;
  logic            redirect_accept;
  logic            stall_cnt_en;

  assign pc_inc         = pc_q + PC_INC;
  assign target_aligned = {redirect_addr[31:2], 2'b00};

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    pending_d       = pending_q;
    fetch_valid_d   = fetch_valid_q;
    misalign_d      = misalign_q;
    pc_stall        = 1'b0;
    if_id_stall     = 1'b0;
    if_id_flush     = 1'b0;
    id_ex_flush     = 1'b0;
    redirect_accept = 1'b0;

    if (!reset) begin
      unique case (state_q)
        PCS_BOOT: begin
          pc_stall      = 1'b1;
          state_d       = PCS_RUN;
          fetch_valid_d = 1'b1;
        end
        PCS_RUN: begin
          if (muldiv_busy) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
          end else if (redirect_valid) begin
            // Redirect outranks stall_req: the stalled instruction is wrong-path.
            if_id_flush     = 1'b1;
            id_ex_flush     = 1'b1;
            redirect_accept = 1'b1;
            if (redirect_addr[1:0] != 2'b00) misalign_d = 1'b1;
            if (imem_ready) begin
              pc_d = target_aligned;
            end else begin
              pc_stall  = 1'b1;
              pending_d = target_aligned;
              state_d   = PCS_PEND;
            end
          end else if (stall_req || !imem_ready) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
          end else begin
            pc_d = pc_inc;
          end
        end
        PCS_PEND: begin
          // EX is already flushed, so any new redirect here is stale.
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          if (imem_ready && !muldiv_busy) begin
            pc_d    = pending_q;
            state_d = PCS_RUN;
          end
        end
        default: state_d = PCS_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= PCS_BOOT;
      pc_q          <= RESET_PC;
      pending_q     <= '0;
      fetch_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pending_q     <= pending_d;
      fetch_valid_q <= fetch_valid_d;
      misalign_q    <= misalign_d;
    end
  end

  assign stall_cnt_en = pc_stall && (state_q != PCS_BOOT);

  perf_counter #(.W(CNT_W)) u_redirect_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (redirect_accept),
    .count (redirect_count)
  );

  perf_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (stall_cnt_en),
    .count (stall_count)
  );

  assign pc           = pc_q;
  assign pc_plus4     = pc_inc;
  assign fetch_valid  = fetch_valid_q;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: vector table with a post-edge
// scoreboard queue, plus hand sequences for PEND and reset-in-PEND.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        stall_req;
  logic        muldiv_busy;
  logic        imem_ready;
  logic [31:0] pc, pc_plus4;
  logic        fetch_valid, pc_stall, if_id_stall, if_id_flush, id_ex_flush;
  logic        misalign_err;
  logic [31:0] redirect_count, stall_count;

  pc_sequencer #(.RESET_PC(32'h0), .CNT_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .stall_req      (stall_req),
    .muldiv_busy    (muldiv_busy),
    .imem_ready     (imem_ready),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .fetch_valid    (fetch_valid),
    .pc_stall       (pc_stall),
    .if_id_stall    (if_id_stall),
    .if_id_flush    (if_id_flush),
    .id_ex_flush    (id_ex_flush),
    .misalign_err   (misalign_err),
    .redirect_count (redirect_count),
    .stall_count    (stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rv;
    logic [31:0] addr;
    logic        st;
    logic        md;
    logic        rdy;
    logic [3:0]  ctl;   // {if_id_flush, id_ex_flush, pc_stall, if_id_stall}
    logic [31:0] npc;
    logic [31:0] rc;
    logic [31:0] sc;
    logic        mis;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] rc;
    logic [31:0] sc;
    logic        mis;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic add(input logic rv, input logic [31:0] addr, input logic st, input logic md,
                     input logic rdy, input logic [3:0] ctl, input logic [31:0] npc,
                     input logic [31:0] rc, input logic [31:0] sc, input logic mis);
    vec_t v;
    v.rv = rv; v.addr = addr; v.st = st; v.md = md; v.rdy = rdy;
    v.ctl = ctl; v.npc = npc; v.rc = rc; v.sc = sc; v.mis = mis;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rv, input logic [31:0] addr, input logic st,
                       input logic md, input logic rdy);
    redirect_valid = rv; redirect_addr = addr; stall_req = st;
    muldiv_busy = md; imem_ready = rdy;
  endtask

  function automatic logic [31:0] ctl_now();
    return {28'd0, if_id_flush, id_ex_flush, pc_stall, if_id_stall};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_pc", pc, 32'h0);
    chk("reset_fetch_valid", {31'd0, fetch_valid}, 32'd0);
    chk("reset_misalign", {31'd0, misalign_err}, 32'd0);
    chk("reset_ctl", ctl_now(), 32'h0);
    chk("reset_rcnt", redirect_count, 32'd0);
    chk("reset_scnt", stall_count, 32'd0);

    reset = 1'b0;
    #1;
    chk("boot_pc", pc, 32'h0);
    chk("boot_fetch_valid", {31'd0, fetch_valid}, 32'd0);
    @(posedge clk); #1;
    chk("run_pc", pc, 32'h0);
    chk("run_fetch_valid", {31'd0, fetch_valid}, 32'd1);

    //   rv  addr           st md rdy ctl      npc            rc sc mis
    add(0, 32'h0,         0, 0, 1, 4'b0000, 32'h4,        0, 0, 0);
    add(0, 32'h0,         0, 0, 1, 4'b0000, 32'h8,        0, 0, 0);
    add(0, 32'h0,         0, 0, 1, 4'b0000, 32'hC,        0, 0, 0);
    add(0, 32'h0,         0, 0, 1, 4'b0000, 32'h10,       0, 0, 0);
    add(1, 32'h100,       0, 0, 1, 4'b1100, 32'h100,      1, 0, 0);
    add(1, 32'h20,        0, 0, 1, 4'b1100, 32'h20,       2, 0, 0);
    add(0, 32'h0,         1, 0, 1, 4'b0011, 32'h20,       2, 1, 0);
    add(0, 32'h0,         1, 0, 1, 4'b0011, 32'h20,       2, 2, 0);
    add(0, 32'h0,         1, 0, 1, 4'b0011, 32'h20,       2, 3, 0);
    add(0, 32'h0,         0, 0, 1, 4'b0000, 32'h24,       2, 3, 0);
    add(1, 32'h102,       0, 0, 1, 4'b1100, 32'h100,      3, 3, 1);
    add(0, 32'h0,         0, 0, 1, 4'b0000, 32'h104,      3, 3, 1);
    add(1, 32'h300,       1, 0, 1, 4'b1100, 32'h300,      4, 3, 1);
    add(1, 32'h400,       1, 1, 1, 4'b0011, 32'h300,      4, 4, 1);
    add(0, 32'h0,         0, 0, 0, 4'b0011, 32'h300,      4, 5, 1);
    add(1, 32'hFFFF_FFFC, 0, 0, 1, 4'b1100, 32'hFFFF_FFFC, 5, 5, 1);
    add(0, 32'h0,         0, 0, 1, 4'b0000, 32'h0,        5, 5, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].rv, vecs[i].addr, vecs[i].st, vecs[i].md, vecs[i].rdy);
      #1;
      chk($sformatf("v%0d_ctl", i), ctl_now(), {28'd0, vecs[i].ctl});
      e.pc = vecs[i].npc; e.rc = vecs[i].rc; e.sc = vecs[i].sc; e.mis = vecs[i].mis;
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      chk($sformatf("v%0d_pc", i), pc, e.pc);
      chk($sformatf("v%0d_pc4", i), pc_plus4, e.pc + 32'd4);
      chk($sformatf("v%0d_rcnt", i), redirect_count, e.rc);
      chk($sformatf("v%0d_scnt", i), stall_count, e.sc);
      chk($sformatf("v%0d_mis", i), {31'd0, misalign_err}, {31'd0, e.mis});
    end

    // Redirect while imem busy: PEND, one-cycle flush, stale redirect ignored.
    @(negedge clk);
    drive(1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
    #1;
    chk("pend_entry_flush", {30'd0, if_id_flush, id_ex_flush}, 32'd3);
    @(posedge clk); #1;
    chk("pend_entry_pc", pc, 32'h0);
    chk("pend_entry_rcnt", redirect_count, 32'd6);
    @(negedge clk);
    drive(1'b1, 32'h500, 1'b0, 1'b0, 1'b0);
    #1;
    chk("pend_flush_low", {30'd0, if_id_flush, id_ex_flush}, 32'd0);
    chk("pend_pc_stall", {31'd0, pc_stall}, 32'd1);
    @(posedge clk); #1;
    chk("pend_hold1_pc", pc, 32'h0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("pend_hold2_pc", pc, 32'h0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("pend_release_pc", pc, 32'h200);
    chk("pend_rcnt", redirect_count, 32'd6);
    @(negedge clk);
    @(posedge clk); #1;
    chk("pend_after_pc", pc, 32'h204);

    // Reset asserted while PEND: pending target must be dropped.
    @(negedge clk);
    drive(1'b1, 32'h600, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("pend2_pc", pc, 32'h204);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    #1;
    chk("rst_pend_pc", pc, 32'h0);
    chk("rst_pend_ctl", ctl_now(), 32'h0);
    chk("rst_pend_rcnt", redirect_count, 32'd0);
    chk("rst_pend_scnt", stall_count, 32'd0);
    chk("rst_pend_mis", {31'd0, misalign_err}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_boot_pc", pc, 32'h0);
    chk("rst_boot_fetch_valid", {31'd0, fetch_valid}, 32'd1);
    @(posedge clk); #1;
    chk("rst_run_pc", pc, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
